// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the interrupt latch.
package irq_pkg;

  localparam int N    = 8;
  localparam int ID_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/irq_latch_if.sv
// Request/acknowledge bundle between the interrupt latch and its consumer.
interface irq_latch_if #(
  parameter int N    = irq_pkg::N,
  parameter int ID_W = irq_pkg::ID_W
);

  logic [N-1:0]    irq;
  logic [N-1:0]    mask;
  logic [N-1:0]    pend;
  logic [N-1:0]    ovf;
  logic            req;
  logic            ack;
  logic [ID_W-1:0] ack_id;
  logic            clr_ovf;

  modport slave (
    input  irq, mask, ack, ack_id, clr_ovf,
    output pend, req, ovf
  );

  modport master (
    output irq, mask, ack, ack_id, clr_ovf,
    input  pend, req, ovf
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous line.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/irq_latch.sv
// Edge-latching interrupt collector with a REQ/ack service handshake.
//
// state | meaning
// IDLE  | nothing offered; waits for any unmasked pending line
// REQ   | req=1, waiting for the consumer's ack (or for pend to vanish)
// HOLD  | one settle cycle for the downstream encoder after an ack
module irq_latch #(
  parameter int N    = irq_pkg::N,
  parameter int ID_W = irq_pkg::ID_W
) (
  input  logic       clk,
  input  logic       rst,
  irq_latch_if.slave bus
);

  import irq_pkg::*;

  logic [N-1:0] w_s2;
  logic [N-1:0] w_edge;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_ovf_set;
  logic [N-1:0] w_pend;

  logic [N-1:0] r_s3;
  logic [N-1:0] r_pending;
  logic [N-1:0] r_ovf;
  logic         r_req;
  state_t       r_state;

  for (genvar g = 0; g < N; g++) begin : g_sync
    sync_2ff u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (bus.irq[g]),
      .o_q   (w_s2[g])
    );
  end

  // Delay the synchronized lines one cycle for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s3 <= '0;
    else     r_s3 <= w_s2;
  end

  assign w_edge = w_s2 & ~r_s3;

  // Decode the acknowledged line; only honoured in REQ, out-of-range ids decode to nothing.
  always_comb begin
    w_clr = '0;
    if (r_state == REQ && bus.ack) begin
      for (int i = 0; i < N; i++) begin
        if (bus.ack_id == ID_W'(i)) w_clr[i] = 1'b1;
      end
    end
  end

  // An edge on a line that stays pending is an overflow; a coinciding clear absorbs it.
  assign w_ovf_set = w_edge & r_pending & ~w_clr;

  // Pending latch: a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr) | w_edge;
  end

  // Sticky overflow flags: a new overflow beats a same-cycle clr_ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_ovf <= '0;
    else if (bus.clr_ovf) r_ovf <= w_ovf_set;
    else                  r_ovf <= r_ovf | w_ovf_set;
  end

  // Mask is applied combinationally so the encoder sees changes immediately.
  assign w_pend = r_pending & ~bus.mask;

  // Service handshake FSM with registered req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_pend) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.ack) begin
            r_state <= HOLD;
            r_req   <= 1'b0;
          end else if (w_pend == '0) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        HOLD: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pend = w_pend;
  assign bus.req  = r_req;
  assign bus.ovf  = r_ovf;

endmodule

// File: doc/irq_latch.md
IRQ_LATCH -- requirements
Module: irq_latch

Interface
REQ-001 Parameter N, default 8, SHALL be the number of request lines.
REQ-002 Parameter ID_W, default 3, SHALL be the width of a line index and SHALL equal clog2(N).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 irq  input  N  SHALL carry asynchronous request lines, rising-edge significant.
REQ-006 mask  input  N  SHALL be the per-line mask; 1 = line hidden from pend.
REQ-007 pend  output  N  SHALL be the masked pending vector feeding the downstream 8-to-3 LSB-priority encoder.
REQ-008 req  output  1  SHALL be the service request to the consumer.
REQ-009 ack  input  1  SHALL be the service acknowledge, single-cycle pulse.
REQ-010 ack_id  input  ID_W  SHALL be the index returned by the encoder, valid when ack=1.
REQ-011 ovf  output  N  SHALL be the sticky per-line overflow flags.
REQ-012 clr_ovf  input  1  SHALL clear all ovf bits when 1.

Function
REQ-013 Each irq bit SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected as s2=1 & s3=0, where s3 is s2 delayed one cycle.
REQ-014 A detected edge SHALL set pending[n] on the next clock: 3 clock edges after the first edge that samples irq[n] high.
REQ-015 pend SHALL be combinational pending & ~mask with no added register stage.
REQ-016 An edge on a line whose pending bit is already 1, and not being cleared that cycle, SHALL set ovf[n]; pending[n] stays 1.
REQ-017 The FSM SHALL have states IDLE, REQ and HOLD; req SHALL be 1 only in REQ.
REQ-018 IDLE SHALL go to REQ when |pend=1; otherwise stay in IDLE.
REQ-019 REQ on ack=1 SHALL clear pending[ack_id] and go to HOLD.
REQ-020 REQ with ack=0 and pend=0 (masked or cleared away) SHALL return to IDLE and drop req on the next cycle.
REQ-021 HOLD SHALL always return to IDLE after exactly one cycle, giving the encoder one settle cycle.
REQ-022 ack in IDLE or HOLD SHALL be ignored: no clear, no state change.
REQ-023 ack with pend[ack_id]=0 in REQ SHALL clear nothing but SHALL still go to HOLD.
REQ-024 ack_id >= N SHALL clear nothing.
REQ-025 When an edge on line n coincides with a clear of line n, set SHALL win: pending[n]=1, ovf[n] unchanged.
REQ-026 When clr_ovf coincides with an overflow event on the same line, set SHALL win: ovf[n]=1.
REQ-027 Mask changes SHALL NOT alter pending or ovf; masked lines SHALL keep latching edges.
REQ-028 Minimum req-to-req spacing SHALL be 3 cycles: REQ, HOLD, IDLE.

Reset
REQ-029 Asserting rst SHALL immediately force synchronizers, s3, pending and ovf to 0, state to IDLE, req to 0 and pend to 0.
REQ-030 Reset mid-handshake SHALL discard the outstanding request; an ack arriving during reset SHALL be ignored.
REQ-031 A line held high through reset release SHALL be seen as a new edge and SHALL set pending 3 edges after release.

Structure
REQ-032 Shared package irq_pkg SHALL hold N, ID_W and the FSM state enum (IDLE, REQ, HOLD).
REQ-033 The synchronizer SHALL be a sub-module sync_2ff (1-bit, async-high reset), instantiated N times.

Verification
REQ-034 irq=0x04 rises at t0, mask=0 -> pend=0x04 at edge 3, req=1 at edge 4; ack with ack_id=2 -> pend=0x00, HOLD, then IDLE.
REQ-035 irq=0x81 rises together -> pend=0x81; ack_id=0 -> pend=0x80; req reasserts 2 cycles later; ack_id=7 -> pend=0x00.
REQ-036 pending=0x08, mask set to 0x08 while in REQ -> pend=0x00, req drops next cycle; mask cleared -> req reasserts.
REQ-037 Second rising edge on irq[1] while pending[1]=1 -> ovf=0x02 and stays set; clr_ovf pulse -> ovf=0x00.
REQ-038 Edge on irq[5] detected in the same cycle as ack with ack_id=5 -> pending[5] stays 1, ovf[5]=0, req reasserts after HOLD.
REQ-039 rst asserted in REQ with pend=0x10 -> req=0, pend=0 immediately; with irq[4] held high, pend=0x10 3 edges after release.
